banked_rom: RTL and testbench

Parametrised, banked, write-lockable program ROM that replaces the flat single-bank ROM on the memory bus. A fixed address window maps onto one of `BANKS` pages, chosen by a bank register. Reads return through a configurable-latency pipeline with a valid strobe instead of a tri-state driver. Writes into the array are allowed only after a two-key unlock sequence, and each unlock permits exactly one program write.

---
 rtl/banked_rom.sv | 129 ++++++++++++
 tb/tb_banked_rom.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_rom.sv
// rtl/banked_rom.sv - banked, write-lockable program ROM with pipelined reads
// A fixed window maps onto one page of the array; each two-key unlock permits one array write.
module banked_rom #(
  parameter int                    WIDTH        = 16,
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE         = 16'h8000,
  parameter int                    WINDOW       = 16384,
  parameter int                    BANKS        = 4,
  parameter int                    READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR    = 16'h7FFE,
  parameter logic [ADDR_WIDTH-1:0] BANK_ADDR    = 16'h7FFF,
  parameter logic [WIDTH-1:0]      KEY1         = 16'hAA55,
  parameter logic [WIDTH-1:0]      KEY2         = 16'h55AA,
  localparam int                   BW           = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data,
  output logic                  read_valid,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  write_protect,
  output logic [BW-1:0]         bank,
  output logic                  unlocked
);

  localparam int DEPTH = BANKS * WINDOW;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    LOCKED    = 2'd0,
    KEY1_SEEN = 2'd1,
    UNLOCKED  = 2'd2
  } state_t;

  state_t                  state;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [READ_LATENCY-1:0] valid_pipe;
  logic [WIDTH-1:0]        data_pipe [READ_LATENCY];

  logic          rd_win, rd_ctrl, rd_bank;
  logic          wr_win, wr_ctrl, wr_bank;
  logic [IW-1:0] rd_idx, wr_idx;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) >= 32'(BASE)) && ((32'(a) - 32'(BASE)) < 32'(WINDOW));
  endfunction

  // 32-bit arithmetic keeps bank*WINDOW + offset from wrapping before truncation
  function automatic logic [IW-1:0] index_of(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [BW-1:0] b);
    return IW'(32'(b) * 32'(WINDOW) + 32'(a) - 32'(BASE));
  endfunction

  always_comb begin
    rd_win  = read_req && in_window(read_addr);
    rd_ctrl = read_req && (read_addr == CTRL_ADDR);
    rd_bank = read_req && (read_addr == BANK_ADDR);
    wr_win  = write_req && in_window(write_addr);
    wr_ctrl = write_req && (write_addr == CTRL_ADDR);
    wr_bank = write_req && (write_addr == BANK_ADDR);
    rd_idx  = index_of(read_addr, bank);
    wr_idx  = index_of(write_addr, bank);
  end

  // Stage 0 samples pre-write values, giving read-before-write on every target.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) data_pipe[i] <= '0;
    end else begin
      valid_pipe[0] <= rd_win || rd_ctrl || rd_bank;
      if (rd_win)       data_pipe[0] <= mem[rd_idx];
      else if (rd_ctrl) data_pipe[0] <= WIDTH'({write_protect, state});
      else if (rd_bank) data_pipe[0] <= WIDTH'(bank);
      else              data_pipe[0] <= '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign read_valid = valid_pipe[READ_LATENCY-1];
  assign read_data  = data_pipe[READ_LATENCY-1];

  always_ff @(posedge clock) begin
    if (!reset && wr_win && (state == UNLOCKED) && !write_protect)
      mem[wr_idx] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= LOCKED;
      unlocked <= 1'b0;
      bank     <= '0;
    end else begin
      if (wr_bank) bank <= BW'(32'(write_data) % 32'(BANKS));
      if (write_protect) begin
        state    <= LOCKED;
        unlocked <= 1'b0;
      end else if (wr_ctrl || wr_win) begin
        case (state)
          LOCKED: begin
            if (wr_ctrl && (write_data == KEY1)) state <= KEY1_SEEN;
            unlocked <= 1'b0;
          end
          KEY1_SEEN: begin
            if (wr_ctrl && (write_data == KEY2)) begin
              state    <= UNLOCKED;
              unlocked <= 1'b1;
            end else begin
              state    <= LOCKED;
              unlocked <= 1'b0;
            end
          end
          default: begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_banked_rom.sv
// tb/tb_banked_rom.sv - self-checking bench for banked_rom
// Reference model: word map, unlock rules and a due-time queue of read results.
module tb_banked_rom;

  localparam int LAT    = 2;
  localparam int WINDOW = 16384;
  localparam int BANKS  = 4;
  localparam int BASE   = 32'h8000;
  localparam logic [15:0] CTRL  = 16'h7FFE;
  localparam logic [15:0] BANKA = 16'h7FFF;
  localparam logic [15:0] KEY1  = 16'hAA55;
  localparam logic [15:0] KEY2  = 16'h55AA;

  logic        clock = 1'b0;
  logic        reset, read_req, write_req, write_protect;
  logic [15:0] read_addr, write_addr, write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic [1:0]  bank;
  logic        unlocked;

  int passed, total, edge_n;
  logic [15:0] mem_m [int];
  int state_m, bank_m;
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t rq[$];
  logic        exp_valid;
  logic [15:0] exp_data;

  banked_rom dut (
    .clock(clock), .reset(reset),
    .read_req(read_req), .read_addr(read_addr), .read_data(read_data), .read_valid(read_valid),
    .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
    .write_protect(write_protect), .bank(bank), .unlocked(unlocked)
  );

  always #5 clock = ~clock;

  // 0 miss, 1 window, 2 control register, 3 bank register
  function automatic int kind(input logic [15:0] a);
    int ai;
    ai = int'(a);
    if (ai >= BASE && ai < BASE + WINDOW) return 1;
    if (a == CTRL) return 2;
    if (a == BANKA) return 3;
    return 0;
  endfunction

  task automatic tick();
    int k, idx;
    logic [15:0] v;
    @(posedge clock);
    edge_n++;
    if (reset) begin
      state_m = 0;
      bank_m  = 0;
      rq.delete();
    end else begin
      if (read_req) begin
        k = kind(read_addr);
        v = 16'h0;
        if (k == 1) begin
          idx = bank_m * WINDOW + (int'(read_addr) - BASE);
          v = mem_m.exists(idx) ? mem_m[idx] : 16'h0;
        end else if (k == 2) v = 16'((int'(write_protect) << 2) | state_m);
        else if (k == 3) v = 16'(bank_m);
        if (k != 0) rq.push_back('{due: edge_n + LAT - 1, data: v});
      end
      k = write_req ? kind(write_addr) : 0;
      idx = bank_m * WINDOW + (int'(write_addr) - BASE);
      if (k == 3) bank_m = int'(write_data) % BANKS;
      if (write_protect) state_m = 0;
      else if (k == 2) begin
        if (state_m == 0 && write_data == KEY1) state_m = 1;
        else if (state_m == 1 && write_data == KEY2) state_m = 2;
        else state_m = 0;
      end else if (k == 1) begin
        if (state_m == 2) mem_m[idx] = write_data;
        state_m = 0;
      end
    end
    exp_valid = (rq.size() > 0) && (rq[0].due == edge_n);
    exp_data  = exp_valid ? rq[0].data : 16'h0;
    if (exp_valid) void'(rq.pop_front());
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    write_req = 1'b1; write_addr = a; write_data = d;
    tick();
    write_req = 1'b0;
  endtask

  task automatic test_reset();
    wr(CTRL, KEY1); wr(CTRL, KEY2); wr(16'h8000, 16'h1234);
    wr(BANKA, 16'd3); wr(CTRL, KEY1); wr(CTRL, KEY2);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    total++;
    if (bank !== 2'd0 || unlocked !== 1'b0 || read_valid !== 1'b0 || read_data !== 16'h0)
      $display("FAIL reset_state got bank=%0d unlocked=%b valid=%b data=%h want 0 0 0 0000", bank, unlocked, read_valid, read_data);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      read_req = (i == 0); read_addr = 16'h8000;
      tick();
      total++;
      if (read_valid !== (i == 1) || read_data !== ((i == 1) ? 16'h1234 : 16'h0000))
        $display("FAIL basic_read cycle=%0d got valid=%b data=%h want valid=%b data=%h", i, read_valid, read_data, (i == 1), (i == 1) ? 16'h1234 : 16'h0000);
      else passed++;
    end
    read_req = 1'b0;
  endtask

  task automatic test_banking();
    logic [15:0] got[$];
    wr(BANKA, 16'd1); wr(CTRL, KEY1); wr(CTRL, KEY2); wr(16'h8000, 16'hBEEF);
    wr(BANKA, 16'd0);
    total++;
    if (bank !== 2'd0) $display("FAIL bank_zero got %0d want 0", bank); else passed++;
    wr(BANKA, 16'd5);
    total++;
    if (bank !== 2'd1) $display("FAIL bank_mod got %0d want 1", bank); else passed++;
    // third read issues alongside a bank change; the captured bank must still be 1
    for (int i = 0; i < 6; i++) begin
      read_req = (i < 3); read_addr = (i == 1) ? BANKA : 16'h8000;
      write_req = (i == 2); write_addr = BANKA; write_data = 16'd0;
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL bank_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
    end
    read_req = 1'b0; write_req = 1'b0;
    total++;
    if (got.size() != 3 || got[0] !== 16'hBEEF || got[1] !== 16'h0001 || got[2] !== 16'hBEEF || bank !== 2'd0)
      $display("FAIL bank_results got n=%0d %p bank=%0d want n=3 beef 0001 beef bank=0", got.size(), got, bank);
    else passed++;
  endtask

  task automatic test_unlock();
    logic [15:0] got[$];
    wr(CTRL, KEY1); wr(CTRL, KEY2);
    total++;
    if (unlocked !== 1'b1) $display("FAIL unlock_set got %b want 1", unlocked); else passed++;
    wr(16'h8010, 16'hCAFE);
    total++;
    if (unlocked !== 1'b0) $display("FAIL unlock_oneshot got %b want 0", unlocked); else passed++;
    wr(16'h8010, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      read_req = (i == 0); read_addr = 16'h8010;
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL unlock_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
    end
    read_req = 1'b0;
    total++;
    if (got.size() != 1 || got[0] !== 16'hCAFE)
      $display("FAIL unlock_readback got n=%0d %p want cafe", got.size(), got);
    else passed++;
  endtask

  task automatic test_bad_key();
    logic [15:0] got[$];
    wr(CTRL, KEY1);
    for (int i = 0; i < 5; i++) begin
      read_req = (i == 0) || (i == 2);
      read_addr = (i == 0) ? CTRL : 16'h8010;
      write_req = (i == 1) || (i == 2);
      write_addr = (i == 1) ? CTRL : 16'h8010;
      write_data = (i == 1) ? 16'h1111 : 16'h7777;
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL badkey_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
    end
    read_req = 1'b1; read_addr = CTRL; write_req = 1'b0;
    tick(); read_req = 1'b0; read_addr = 16'h8010; read_req = 1'b1;
    tick(); read_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL badkey_tail cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
      tick();
    end
    total++;
    if (got.size() != 4 || got[0] !== 16'h0001 || got[1] !== 16'hCAFE || got[2] !== 16'h0000 || got[3] !== 16'hCAFE)
      $display("FAIL badkey_results got n=%0d %p want 0001 cafe 0000 cafe", got.size(), got);
    else passed++;
  endtask

  task automatic test_protect();
    logic [15:0] got[$];
    wr(CTRL, KEY1); wr(CTRL, KEY2); wr(16'h8001, 16'h0101);
    wr(CTRL, KEY1); wr(CTRL, KEY2);
    total++;
    if (unlocked !== 1'b1) $display("FAIL protect_pre got %b want 1", unlocked); else passed++;
    write_protect = 1'b1;
    wr(16'h8001, 16'hDEAD);
    total++;
    if (unlocked !== 1'b0) $display("FAIL protect_lock got %b want 0", unlocked); else passed++;
    for (int i = 0; i < 5; i++) begin
      read_req = (i < 2); read_addr = (i == 0) ? CTRL : 16'h8001;
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL protect_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
    end
    read_req = 1'b0;
    total++;
    if (got.size() != 2 || got[0] !== 16'h0004 || got[1] !== 16'h0101)
      $display("FAIL protect_results got n=%0d %p want 0004 0101", got.size(), got);
    else passed++;
    wr(CTRL, KEY1); wr(CTRL, KEY2);
    total++;
    if (unlocked !== 1'b0) $display("FAIL protect_unlock_blocked got %b want 0", unlocked); else passed++;
    write_protect = 1'b0;
    tick();
  endtask

  task automatic test_pipeline_reset();
    int late = 0;
    for (int i = 0; i < 8; i++) begin
      read_req = (i < 3); read_addr = 16'h8000 + 16'(i);
      reset = (i == 3);
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL pipe_reset_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (i >= 3 && read_valid) late++;
    end
    reset = 1'b0; read_req = 1'b0;
    total++;
    if (late != 0) $display("FAIL pipe_flush got %0d strobes after reset want 0", late); else passed++;
  endtask

  task automatic test_same_cycle();
    logic [15:0] got[$];
    wr(CTRL, KEY1); wr(CTRL, KEY2); wr(16'h8020, 16'h2020);
    wr(CTRL, KEY1); wr(CTRL, KEY2);
    for (int i = 0; i < 6; i++) begin
      read_req = (i < 4); read_addr = (i < 2) ? 16'h8020 : BANKA;
      write_req = (i == 0) || (i == 2);
      write_addr = (i == 0) ? 16'h8020 : BANKA;
      write_data = (i == 0) ? 16'h3030 : 16'd2;
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data)
        $display("FAIL same_cycle_stream cycle=%0d got %b/%h want %b/%h", i, read_valid, read_data, exp_valid, exp_data);
      else passed++;
      if (read_valid) got.push_back(read_data);
    end
    read_req = 1'b0; write_req = 1'b0;
    total++;
    if (got.size() != 4 || got[0] !== 16'h2020 || got[1] !== 16'h3030 || got[2] !== 16'h0000 || got[3] !== 16'h0002)
      $display("FAIL same_cycle_results got n=%0d %p want 2020 3030 0000 0002", got.size(), got);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] addrs[8] = '{16'h8000, 16'h8001, 16'h8020, 16'hBFFF, 16'hC000, 16'h7FFD, 16'h7FFE, 16'h7FFF};
    for (int b = 0; b < BANKS; b++) begin
      wr(BANKA, 16'(b));
      for (int j = 0; j < 4; j++) begin
        wr(CTRL, KEY1); wr(CTRL, KEY2); wr(addrs[j], 16'($urandom));
      end
    end
    for (int i = 0; i < 800; i++) begin
      read_req  = 1'($urandom_range(0, 1));
      read_addr = addrs[$urandom_range(0, 7)];
      write_req = 1'($urandom_range(0, 1));
      write_addr = ($urandom_range(0, 1) == 1) ? CTRL : addrs[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
        0: write_data = KEY1;
        1: write_data = KEY2;
        2: write_data = KEY1;
        default: write_data = 16'($urandom);
      endcase
      write_protect = ($urandom_range(0, 15) == 0);
      tick();
      total++;
      if (read_valid !== exp_valid || read_data !== exp_data || bank !== 2'(bank_m) || unlocked !== (state_m == 2))
        $display("FAIL random cycle=%0d got %b/%h bank=%0d unl=%b want %b/%h bank=%0d unl=%b", i, read_valid, read_data, bank, unlocked, exp_valid, exp_data, bank_m, (state_m == 2));
      else passed++;
    end
    read_req = 1'b0; write_req = 1'b0; write_protect = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0; edge_n = 0; state_m = 0; bank_m = 0;
    reset = 1'b1; read_req = 1'b0; write_req = 1'b0; write_protect = 1'b0;
    read_addr = '0; write_addr = '0; write_data = '0;
    tick(); tick();
    reset = 1'b0;
    test_reset();
    test_banking();
    test_unlock();
    test_bad_key();
    test_protect();
    test_pipeline_reset();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
